multicycle_control_unit: RTL and testbench

- Multicycle successor to the single-cycle control path: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives a shared-memory, single-ALU RV32I datapath.
- Parametrised ALU-control width (adds shift/XOR codes), optional memory wait states through a ready handshake, and optional multi-cycle M-extension sequencing.
- Sits between the instruction register and the datapath muxes/enables.

---
 rtl/mcu_pkg.sv | 71 +++++++
 rtl/mc_alu_decoder.sv | 61 ++++++
 rtl/multicycle_control_unit.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mcu_pkg                                                              |
// | Shared encodings for the multicycle RV32I control unit.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mcu_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECR    = 4'd6;
  localparam state_t S_EXECI    = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_JAL      = 4'd9;
  localparam state_t S_BRANCH   = 4'd10;
  localparam state_t S_MDUWAIT  = 4'd11;
  localparam state_t S_TRAP     = 4'd12;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } aluop_e;

  // Full 4-bit code space; narrow builds keep only the low three bits.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_MDU    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mc_alu_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_alu_decoder                                                       |
// | Combinational ALU-control decode from ALUOp, funct3 and funct7[5].   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mc_alu_decoder
  import mcu_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  aluop_e                aluop,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  unsupported
);

  logic [3:0] w_code;
  logic       w_ext;
  logic       w_bad;

  always_comb begin
    w_code = ALU_ADD;
    w_ext  = 1'b0;
    w_bad  = 1'b0;
    case (aluop)
      ALUOP_ADD: w_code = ALU_ADD;
      ALUOP_SUB: w_code = ALU_SUB;
      default: begin
        case (funct3)
          // Immediates never subtract: funct7[5] only matters for R-type here.
          3'b000: w_code = (aluop == ALUOP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010: w_code = ALU_SLT;
          3'b110: w_code = ALU_OR;
          3'b111: w_code = ALU_AND;
          3'b100: begin w_code = ALU_XOR; w_ext = 1'b1; end
          3'b001: begin w_code = ALU_SLL; w_ext = 1'b1; end
          3'b101: begin w_code = funct7_5 ? ALU_SRA : ALU_SRL; w_ext = 1'b1; end
          default: w_bad = 1'b1;
        endcase
      end
    endcase
  end

  generate
    if (ALU_CTRL_W >= 4) begin : g_wide
      logic w_unused_ext;
      assign w_unused_ext = w_ext;
      assign alu_ctrl     = w_code[ALU_CTRL_W-1:0];
      assign unsupported  = w_bad;
    end else begin : g_base
      logic w_unused_hi;
      assign w_unused_hi = w_code[3];
      assign alu_ctrl    = w_code[ALU_CTRL_W-1:0];
      assign unsupported = w_bad | w_ext;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_control_unit                                              |
// | Moore FSM sequencing a shared-memory, single-ALU RV32I datapath.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int MEM_WAIT   = 1,
  parameter int M_EXT      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            Op,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  Zero,
  input  logic                  mem_ready,
  input  logic                  mdu_done,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  mdu_start,
  output logic                  illegal_instr,
  output logic [3:0]            state_o
);

  state_t r_state;
  state_t w_next;
  state_t w_out_state;
  logic   r_illegal;
  logic   w_mem_rdy;
  aluop_e w_aluop;
  logic   w_dec_bad;
  logic   w_is_mdu;
  logic   w_branch_ok;
  logic   w_pcwrite;
  logic   w_irwrite;
  logic   w_memwrite;
  logic   w_regwrite;
  logic   w_mdu_start;

  generate
    if (MEM_WAIT != 0) begin : g_mem_wait
      assign w_mem_rdy = mem_ready;
    end else begin : g_no_wait
      logic w_unused_ready;
      assign w_unused_ready = mem_ready;
      assign w_mem_rdy      = 1'b1;
    end
  endgenerate

  assign w_is_mdu    = (funct7 == F7_MULDIV);
  assign w_branch_ok = (funct3[2:1] == 2'b00);

  mc_alu_decoder #(
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_dec (
    .aluop       (w_aluop),
    .funct3      (funct3),
    .funct7_5    (funct7[5]),
    .alu_ctrl    (ALUControl),
    .unsupported (w_dec_bad)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (w_mem_rdy) w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_JAL:            w_next = S_JAL;
          OP_BRANCH:         w_next = S_BRANCH;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next = (Op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (w_mem_rdy) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (w_mem_rdy) w_next = S_FETCH;
      S_EXECR: begin
        if (w_is_mdu)       w_next = (M_EXT != 0) ? S_MDUWAIT : S_TRAP;
        else if (w_dec_bad) w_next = S_TRAP;
        else                w_next = S_ALUWB;
      end
      S_EXECI:    w_next = w_dec_bad ? S_TRAP : S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_BRANCH:   w_next = w_branch_ok ? S_FETCH : S_TRAP;
      S_MDUWAIT:  if (mdu_done) w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
    end
  end

  // Under reset the datapath sees FETCH steering with every enable held low.
  always_comb begin
    w_out_state = rst ? S_FETCH : r_state;
    w_pcwrite   = 1'b0;
    w_irwrite   = 1'b0;
    w_memwrite  = 1'b0;
    w_regwrite  = 1'b0;
    w_mdu_start = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    ImmSrc      = IMM_I;
    w_aluop     = ALUOP_ADD;
    case (w_out_state)
      S_FETCH: begin
        w_irwrite = w_mem_rdy;
        w_pcwrite = w_mem_rdy;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (Op == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (Op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        w_regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA     = SRCA_RS1;
        ALUSrcB     = SRCB_RS2;
        w_aluop     = ALUOP_RTYPE;
        w_mdu_start = (M_EXT != 0) && w_is_mdu;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_I;
        w_aluop = ALUOP_ITYPE;
      end
      S_ALUWB: w_regwrite = 1'b1;
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        w_pcwrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        ImmSrc    = IMM_B;
        w_aluop   = ALUOP_SUB;
        w_pcwrite = w_branch_ok & (Zero ^ funct3[0]);
      end
      S_MDUWAIT: begin
        ResultSrc  = RES_MDU;
        w_regwrite = mdu_done;
      end
      default: ;
    endcase
  end

  assign PCWrite       = w_pcwrite   & ~rst;
  assign IRWrite       = w_irwrite   & ~rst;
  assign MemWrite      = w_memwrite  & ~rst;
  assign RegWrite      = w_regwrite  & ~rst;
  assign mdu_start     = w_mdu_start & ~rst;
  assign illegal_instr = r_illegal;
  assign state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multicycle_control_unit                                           |
// | Directed bench: base build (3-bit ALU, no M) and extended build.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       mem_ready;
  logic       mdu_done;

  logic       a_PCWrite, a_AdrSrc, a_MemWrite, a_IRWrite, a_RegWrite;
  logic [1:0] a_ResultSrc, a_ALUSrcA, a_ALUSrcB, a_ImmSrc;
  logic [2:0] a_ALUControl;
  logic       a_mdu_start, a_illegal;
  logic [3:0] a_state;

  logic       x_PCWrite, x_AdrSrc, x_MemWrite, x_IRWrite, x_RegWrite;
  logic [1:0] x_ResultSrc, x_ALUSrcA, x_ALUSrcB, x_ImmSrc;
  logic [3:0] x_ALUControl;
  logic       x_mdu_start, x_illegal;
  logic [3:0] x_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          rw_cnt;
  int          st_cnt;
  logic [27:0] seq;

  always #5 clk = ~clk;

  multicycle_control_unit #(.ALU_CTRL_W(3), .MEM_WAIT(1), .M_EXT(0)) dut (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .mdu_done(mdu_done),
    .PCWrite(a_PCWrite), .AdrSrc(a_AdrSrc), .MemWrite(a_MemWrite),
    .IRWrite(a_IRWrite), .RegWrite(a_RegWrite), .ResultSrc(a_ResultSrc),
    .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB), .ImmSrc(a_ImmSrc),
    .ALUControl(a_ALUControl), .mdu_start(a_mdu_start),
    .illegal_instr(a_illegal), .state_o(a_state)
  );

  multicycle_control_unit #(.ALU_CTRL_W(4), .MEM_WAIT(1), .M_EXT(1)) dut_x (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .mdu_done(mdu_done),
    .PCWrite(x_PCWrite), .AdrSrc(x_AdrSrc), .MemWrite(x_MemWrite),
    .IRWrite(x_IRWrite), .RegWrite(x_RegWrite), .ResultSrc(x_ResultSrc),
    .ALUSrcA(x_ALUSrcA), .ALUSrcB(x_ALUSrcB), .ImmSrc(x_ImmSrc),
    .ALUControl(x_ALUControl), .mdu_start(x_mdu_start),
    .illegal_instr(x_illegal), .state_o(x_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; Op = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    Zero = 1'b0; mem_ready = 1'b1; mdu_done = 1'b0;
    nxt(); #1;
    check("rst_state",     a_state, 0);
    check("rst_irwrite",   a_IRWrite, 0);
    check("rst_pcwrite",   a_PCWrite, 0);
    check("rst_illegal",   a_illegal, 0);
    check("rst_alusrcb",   a_ALUSrcB, 2);
    check("rst_resultsrc", a_ResultSrc, 2);

    // add x3,x1,x2
    rst = 1'b0; Op = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000; #1;
    check("add_fetch_ir", a_IRWrite, 1);
    check("add_fetch_rw", a_RegWrite, 0);
    nxt(); #1;
    check("add_s_decode", a_state, 1);
    check("add_rw_decode", a_RegWrite, 0);
    nxt(); #1;
    check("add_s_execr", a_state, 6);
    check("add_aluctrl", a_ALUControl, 0);
    check("add_rw_execr", a_RegWrite, 0);
    nxt(); #1;
    check("add_s_aluwb", a_state, 8);
    check("add_rw_aluwb", a_RegWrite, 1);
    check("add_res_aluwb", a_ResultSrc, 0);
    nxt(); #1;
    check("add_s_back", a_state, 0);

    // lw with two not-ready cycles in MEMREAD
    Op = 7'b0000011; funct3 = 3'b010;
    seq = 28'h0123334;
    rw_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      mem_ready = (i == 3 || i == 4) ? 1'b0 : 1'b1;
      #1;
      check("lw_state", a_state, seq[4*(6-i) +: 4]);
      if (a_RegWrite) rw_cnt++;
      if (i == 6) check("lw_res_memwb", a_ResultSrc, 1);
      nxt();
    end
    mem_ready = 1'b1; #1;
    check("lw_s_back", a_state, 0);
    check("lw_regwrite_cnt", rw_cnt, 1);

    // beq Zero=1 taken, bne Zero=1 not taken, bne Zero=0 taken
    Op = 7'b1100011; Zero = 1'b1;
    for (int k = 0; k < 3; k++) begin
      funct3 = (k == 0) ? 3'b000 : 3'b001;
      Zero   = (k == 2) ? 1'b0 : 1'b1;
      nxt(); #1;
      check("br_decode_imm", a_ImmSrc, 2);
      nxt(); #1;
      check("br_state", a_state, 10);
      check("br_pcwrite", a_PCWrite, (k == 1) ? 0 : 1);
      check("br_aluctrl", a_ALUControl, 1);
      nxt(); #1;
      check("br_s_back", a_state, 0);
    end
    Zero = 1'b0;

    // sra: legal on the 4-bit build, trap on the 3-bit build
    Op = 7'b0110011; funct3 = 3'b101; funct7 = 7'b0100000;
    nxt(); nxt(); #1;
    check("sra_x_state", x_state, 6);
    check("sra_x_aluctrl", x_ALUControl, 8);
    nxt(); #1;
    check("sra_a_trap", a_state, 12);
    check("sra_a_illegal", a_illegal, 1);
    check("sra_x_aluwb", x_state, 8);
    check("sra_x_illegal", x_illegal, 0);
    nxt(); #1;
    check("sra_a_stays", a_state, 12);
    check("sra_a_rw", a_RegWrite, 0);
    check("sra_x_back", x_state, 0);

    rst = 1'b1;
    nxt(); #1;
    check("rst2_illegal", a_illegal, 0);
    check("rst2_state", a_state, 0);
    rst = 1'b0;

    // mul: done pulse five cycles after the start cycle
    Op = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000001;
    rw_cnt = 0; st_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      mdu_done = (i == 7);
      #1;
      if (x_mdu_start) st_cnt++;
      if (x_RegWrite) rw_cnt++;
      if (i == 2) check("mul_start_pulse", x_mdu_start, 1);
      if (i == 2) check("mul_a_no_start", a_mdu_start, 0);
      if (i == 3) check("mul_a_trap", a_state, 12);
      if (i == 5) check("mul_x_wait", x_state, 11);
      if (i == 7) begin
        check("mul_rw_done", x_RegWrite, 1);
        check("mul_res_done", x_ResultSrc, 3);
      end
      nxt();
    end
    mdu_done = 1'b0; #1;
    check("mul_x_back", x_state, 0);
    check("mul_start_cnt", st_cnt, 1);
    check("mul_rw_cnt", rw_cnt, 1);
    check("mul_a_illegal", a_illegal, 1);

    // sw, reset arrives while MEMWRITE is stalled
    rst = 1'b1;
    nxt();
    rst = 1'b0; Op = 7'b0100011; funct3 = 3'b010; funct7 = 7'b0000000;
    nxt(); nxt(); #1;
    check("sw_s_memadr", a_state, 2);
    check("sw_imm_s", a_ImmSrc, 1);
    nxt();
    mem_ready = 1'b0; #1;
    check("sw_s_memwrite", a_state, 5);
    check("sw_memwrite", a_MemWrite, 1);
    check("sw_adrsrc", a_AdrSrc, 1);
    nxt();
    rst = 1'b1; #1;
    check("sw_rst_memwrite", a_MemWrite, 0);
    check("sw_rst_held", a_state, 5);
    nxt(); #1;
    check("sw_rst_fetch", a_state, 0);
    check("sw_rst_illegal", a_illegal, 0);
    rst = 1'b0; mem_ready = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
